// File: rtl/regfile_pkg.sv
// Shared defaults for the multiport register file and a helper that locates
// a port's slice inside a packed multi-port bus.
package regfile_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_NUM_RD = 2;
  localparam int DEF_NUM_WR = 2;

  // Slice widths of one port inside the packed address and data buses
  localparam int ADDR_SLICE = DEF_ADDR_W;
  localparam int DATA_SLICE = DEF_DATA_W;

  function automatic int slice_lo(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/multiport_regfile_if.sv
// Bundles the read, write and reservation ports of the register file.
// The master drives requests; the slave (the register file) returns read data.
interface multiport_regfile_if
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_SLICE,
  parameter int ADDR_W = ADDR_SLICE,
  parameter int NUM_RD = DEF_NUM_RD,
  parameter int NUM_WR = DEF_NUM_WR
) ();

  logic [NUM_RD-1:0]        RdEn;
  logic [NUM_RD*ADDR_W-1:0] RdAddr;
  logic [NUM_RD*DATA_W-1:0] RdData;
  logic [NUM_RD-1:0]        RdBusy;
  logic [NUM_WR-1:0]        WrEn;
  logic [NUM_WR*ADDR_W-1:0] WrAddr;
  logic [NUM_WR*DATA_W-1:0] WrData;
  logic                     ResvEn;
  logic [ADDR_W-1:0]        ResvAddr;

  modport master (
    output RdEn, RdAddr, WrEn, WrAddr, WrData, ResvEn, ResvAddr,
    input  RdData, RdBusy
  );

  modport slave (
    input  RdEn, RdAddr, WrEn, WrAddr, WrData, ResvEn, ResvAddr,
    output RdData, RdBusy
  );

endinterface

// File: rtl/regfile_scoreboard.sv
// One pending-write bit per register: set by a reservation, cleared by a write.
// Exposes the post-edge busy state of each read address.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W   = ADDR_SLICE,
  parameter int NUM_RD   = DEF_NUM_RD,
  parameter int NUM_WR   = DEF_NUM_WR,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     resv_en,
  input  logic [ADDR_W-1:0]        resv_addr,
  input  logic [NUM_WR-1:0]        clr_en,
  input  logic [NUM_WR*ADDR_W-1:0] clr_addr,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD-1:0]        rd_busy_next
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] busy_next;

  // NOTE: every always_comb output is assigned a default first so no path leaves it unassigned (no latch).
  always_comb begin
    busy_next = busy;
    for (int w = 0; w < NUM_WR; w++) begin
      if (clr_en[w]) busy_next[clr_addr[slice_lo(w, ADDR_W) +: ADDR_W]] = 1'b0;
    end
    // Reservation is applied after the clears so it wins a same-cycle collision
    if (resv_en && !(ZERO_REG && resv_addr == '0)) busy_next[resv_addr] = 1'b1;
  end

  always_comb begin
    rd_busy_next = '0;
    for (int r = 0; r < NUM_RD; r++) begin
      rd_busy_next[r] = busy_next[rd_addr[slice_lo(r, ADDR_W) +: ADDR_W]];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy <= '0;
    else        busy <= busy_next;
  end

endmodule

// File: rtl/multiport_regfile.sv
// Multi-read, multi-write register file with write-to-read bypass, optional
// hardwired zero register and a pending-write scoreboard.
module multiport_regfile
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_SLICE,
  parameter int ADDR_W   = ADDR_SLICE,
  parameter int NUM_RD   = DEF_NUM_RD,
  parameter int NUM_WR   = DEF_NUM_WR,
  parameter bit ZERO_REG = 1'b1
) (
  input logic                CLOCK,
  input logic                RESET,
  multiport_regfile_if.slave bus
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0]        regs [DEPTH];
  logic [NUM_WR-1:0]        wr_ok;
  logic [DATA_W-1:0]        rd_value [NUM_RD];
  logic [NUM_RD-1:0]        rd_busy_next;
  logic [NUM_RD*DATA_W-1:0] rd_data_q;
  logic [NUM_RD-1:0]        rd_busy_q;

  // Writes to the zero register are dropped here, so regs[0] stays 0 forever
  always_comb begin
    wr_ok = '0;
    for (int w = 0; w < NUM_WR; w++) begin
      wr_ok[w] = bus.WrEn[w] &&
                 !(ZERO_REG && bus.WrAddr[slice_lo(w, ADDR_W) +: ADDR_W] == '0);
    end
  end

  // NOTE: the storage array is reset because the zero-on-reset contents are architecturally visible.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      for (int a = 0; a < DEPTH; a++) regs[a] <= '0;
    end else begin
      // NOTE: with non-blocking assignments the last one in loop order lands, so the highest port wins.
      for (int w = 0; w < NUM_WR; w++) begin
        if (wr_ok[w]) regs[bus.WrAddr[slice_lo(w, ADDR_W) +: ADDR_W]]
                        <= bus.WrData[slice_lo(w, DATA_W) +: DATA_W];
      end
    end
  end

  always_comb begin
    for (int r = 0; r < NUM_RD; r++) begin
      rd_value[r] = regs[bus.RdAddr[slice_lo(r, ADDR_W) +: ADDR_W]];
      for (int w = 0; w < NUM_WR; w++) begin
        if (wr_ok[w] && bus.WrAddr[slice_lo(w, ADDR_W) +: ADDR_W] ==
                        bus.RdAddr[slice_lo(r, ADDR_W) +: ADDR_W])
          rd_value[r] = bus.WrData[slice_lo(w, DATA_W) +: DATA_W];
      end
    end
  end

  regfile_scoreboard #(
    .ADDR_W  (ADDR_W),
    .NUM_RD  (NUM_RD),
    .NUM_WR  (NUM_WR),
    .ZERO_REG(ZERO_REG)
  ) u_scoreboard (
    .clk         (CLOCK),
    .rst_n       (RESET),
    .resv_en     (bus.ResvEn),
    .resv_addr   (bus.ResvAddr),
    .clr_en      (wr_ok),
    .clr_addr    (bus.WrAddr),
    .rd_addr     (bus.RdAddr),
    .rd_busy_next(rd_busy_next)
  );

  // Busy is captured alongside data so both describe the same post-edge state
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      rd_data_q <= '0;
      rd_busy_q <= '0;
    end else begin
      for (int r = 0; r < NUM_RD; r++) begin
        if (bus.RdEn[r]) begin
          rd_data_q[slice_lo(r, DATA_W) +: DATA_W] <= rd_value[r];
          rd_busy_q[r]                             <= rd_busy_next[r];
        end
      end
    end
  end

  assign bus.RdData = rd_data_q;
  assign bus.RdBusy = rd_busy_q;

endmodule

// File: tb/tb_multiport_regfile.sv
// Directed-vector bench for multiport_regfile (32-bit, 32 entries, 2R/2W).
// Outputs are compared 1 ns after each rising edge against hand-computed values.
module tb_multiport_regfile;
  import regfile_pkg::*;

  typedef struct {
    logic [1:0]  we;
    logic [4:0]  wa0, wa1;
    logic [31:0] wd0, wd1;
    logic        rv;
    logic [4:0]  rva;
    logic [1:0]  re;
    logic [4:0]  ra0, ra1;
    logic [31:0] e0, e1;
    logic [1:0]  eb;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;
  vec_t vecs [14];

  always #5 clk = ~clk;

  multiport_regfile_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .NUM_WR(2)) bus ();

  multiport_regfile #(
    .DATA_W(32), .ADDR_W(5), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(1'b1)
  ) dut (
    .CLOCK(clk),
    .RESET(rst_n),
    .bus  (bus)
  );

  function automatic vec_t mk(
    input logic [1:0] we, input logic [4:0] wa0, input logic [31:0] wd0,
    input logic [4:0] wa1, input logic [31:0] wd1,
    input logic rv, input logic [4:0] rva,
    input logic [1:0] re, input logic [4:0] ra0, input logic [4:0] ra1,
    input logic [31:0] e0, input logic [31:0] e1, input logic [1:0] eb);
    vec_t v;
    v.we = we; v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1; v.wd1 = wd1;
    v.rv = rv; v.rva = rva; v.re = re; v.ra0 = ra0; v.ra1 = ra1;
    v.e0 = e0; v.e1 = e1; v.eb = eb;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    bus.WrEn     = v.we;
    bus.WrAddr   = {v.wa1, v.wa0};
    bus.WrData   = {v.wd1, v.wd0};
    bus.ResvEn   = v.rv;
    bus.ResvAddr = v.rva;
    bus.RdEn     = v.re;
    bus.RdAddr   = {v.ra1, v.ra0};
  endtask

  task automatic check(input string name, input logic [31:0] e1,
                       input logic [31:0] e0, input logic [1:0] eb);
    logic [65:0] act;
    logic [65:0] exp;
    act = {bus.RdData, bus.RdBusy};
    exp = {e1, e0, eb};
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got data1=%h data0=%h busy=%b, want data1=%h data0=%h busy=%b",
               name, act[65:34], act[33:2], act[1:0], e1, e0, eb);
    end
  endtask

  task automatic step(input vec_t v);
    @(negedge clk);
    drive(v);
    @(posedge clk);
    #1;
  endtask

  vec_t idle;

  initial begin
    idle = mk(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 2'b00);

    //           we     wa0  wd0           wa1  wd1     rv  rva  re     ra0  ra1  e0            e1            eb
    vecs[0]  = mk(2'b01, 5, 32'hDEADBEEF,  0, 32'h0,  0,  0, 2'b00,  0,  0, 32'h0,        32'h0,        2'b00);
    vecs[1]  = mk(2'b00, 0, 32'h0,         0, 32'h0,  0,  0, 2'b11,  5,  5, 32'hDEADBEEF, 32'hDEADBEEF, 2'b00);
    vecs[2]  = mk(2'b11, 7, 32'h11,        7, 32'h22, 0,  0, 2'b01,  7,  5, 32'h22,       32'hDEADBEEF, 2'b00);
    vecs[3]  = mk(2'b00, 0, 32'h0,         0, 32'h0,  0,  0, 2'b11,  7,  7, 32'h22,       32'h22,       2'b00);
    vecs[4]  = mk(2'b01, 0, 32'hFFFFFFFF,  0, 32'h0,  1,  0, 2'b11,  0,  0, 32'h0,        32'h0,        2'b00);
    vecs[5]  = mk(2'b00, 0, 32'h0,         0, 32'h0,  0,  0, 2'b11,  0,  0, 32'h0,        32'h0,        2'b00);
    vecs[6]  = mk(2'b00, 0, 32'h0,         0, 32'h0,  1,  9, 2'b11,  9,  5, 32'h0,        32'hDEADBEEF, 2'b01);
    vecs[7]  = mk(2'b00, 0, 32'h0,         0, 32'h0,  0,  0, 2'b01,  9,  5, 32'h0,        32'hDEADBEEF, 2'b01);
    vecs[8]  = mk(2'b10, 0, 32'h0,         9, 32'h5,  0,  0, 2'b01,  9,  5, 32'h5,        32'hDEADBEEF, 2'b00);
    vecs[9]  = mk(2'b01, 9, 32'h6,         0, 32'h0,  1,  9, 2'b10,  0,  9, 32'h5,        32'h6,        2'b10);
    vecs[10] = mk(2'b00, 0, 32'h0,         0, 32'h0,  0,  0, 2'b11,  9,  9, 32'h6,        32'h6,        2'b11);
    vecs[11] = mk(2'b11, 12, 32'h1234,    13, 32'h5678, 0, 0, 2'b11, 13, 12, 32'h5678,     32'h1234,     2'b00);
    vecs[12] = mk(2'b01, 7, 32'h33,        7, 32'h44, 0,  0, 2'b01,  7,  0, 32'h33,       32'h1234,     2'b00);
    vecs[13] = mk(2'b01, 9, 32'h77,        0, 32'h0,  1, 20, 2'b11, 20,  9, 32'h0,        32'h77,       2'b01);

    drive(idle);
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", 32'h0, 32'h0, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      step(vecs[i]);
      check($sformatf("vec%0d", i), vecs[i].e1, vecs[i].e0, vecs[i].eb);
    end

    // Hold: port 0 keeps its last read value while RdEn is low
    step(mk(2'b01, 3, 32'hA, 0, 32'h0, 0, 0, 2'b00, 3, 9, 32'h0, 32'h0, 2'b00));
    step(mk(2'b00, 0, 32'h0, 0, 32'h0, 0, 0, 2'b01, 3, 9, 32'h0, 32'h0, 2'b00));
    check("hold_read_a", 32'h77, 32'hA, 2'b00);
    step(mk(2'b01, 3, 32'hB, 0, 32'h0, 0, 0, 2'b00, 3, 9, 32'h0, 32'h0, 2'b00));
    check("hold_during_write", 32'h77, 32'hA, 2'b00);
    step(idle);
    check("hold_idle", 32'h77, 32'hA, 2'b00);
    step(mk(2'b00, 0, 32'h0, 0, 32'h0, 0, 0, 2'b01, 3, 9, 32'h0, 32'h0, 2'b00));
    check("hold_reread_b", 32'h77, 32'hB, 2'b00);

    // Mid-stream asynchronous reset, with a write and reservation held off by reset
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", 32'h0, 32'h0, 2'b00);
    step(mk(2'b01, 2, 32'h99, 0, 32'h0, 1, 2, 2'b11, 2, 2, 32'h0, 32'h0, 2'b00));
    @(negedge clk);
    rst_n = 1'b1;
    drive(mk(2'b01, 4, 32'h88, 0, 32'h0, 0, 0, 2'b11, 1, 2, 32'h0, 32'h0, 2'b00));
    @(posedge clk);
    #1;
    check("first_edge_after_reset", 32'h0, 32'h0, 2'b00);

    for (int a = 1; a < 32; a++) begin
      logic [4:0]  a0;
      logic [4:0]  a1;
      logic [31:0] x0;
      logic [31:0] x1;
      a0 = 5'(a);
      a1 = 5'(32 - a);
      x0 = (a0 == 5'd4) ? 32'h88 : 32'h0;
      x1 = (a1 == 5'd4) ? 32'h88 : 32'h0;
      step(mk(2'b00, 0, 32'h0, 0, 32'h0, 0, 0, 2'b11, a0, a1, 32'h0, 32'h0, 2'b00));
      check($sformatf("post_reset_r%0d", a), x1, x0, 2'b00);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/multiport_regfile.md
MULTIPORT_REGFILE -- requirements
Module: multiport_regfile

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register width in bits.
REQ-002 SHALL have parameter ADDR_W, default 5, address width; depth = 2**ADDR_W.
REQ-003 SHALL have parameter NUM_RD, default 2, number of read ports.
REQ-004 SHALL have parameter NUM_WR, default 2, number of write ports.
REQ-005 SHALL have parameter ZERO_REG, default 1, where 1 hardwires register 0 to zero.
REQ-006 SHALL have ports (one clock; reset is asynchronous and active-low):
  CLOCK      input   1               system clock, rising edge
  RESET      input   1               asynchronous reset, active-low
  RdEn       input   NUM_RD          per-port read enable
  RdAddr     input   NUM_RD*ADDR_W   packed read addresses, port i at [i*ADDR_W +: ADDR_W]
  RdData     output  NUM_RD*DATA_W   packed registered read data
  RdBusy     output  NUM_RD          registered: read register had a pending write
  WrEn       input   NUM_WR          per-port write enable
  WrAddr     input   NUM_WR*ADDR_W   packed write addresses
  WrData     input   NUM_WR*DATA_W   packed write data
  ResvEn     input   1               reserve a destination: mark pending
  ResvAddr   input   ADDR_W          register to reserve

Function
REQ-007 SHALL perform writes on the rising CLOCK edge for each port with WrEn=1.
REQ-008 SHALL resolve two write ports targeting the same address in one cycle in favour of the highest-indexed port.
REQ-009 SHALL, with ZERO_REG=1, ignore writes and reservations to address 0, return 0 on reads of address 0, and never report it busy.
REQ-010 SHALL update RdData port i on the edge where RdEn[i]=1, giving 1-cycle read latency, and hold RdData[i] when RdEn[i]=0.
REQ-011 SHALL bypass: a read and a write to the same address in the same cycle returns the new WrData, with REQ-008 priority.
REQ-012 SHALL keep one busy bit per register, set by ResvEn on the edge and cleared by any write to that address.
REQ-013 SHALL, on simultaneous reserve and write to the same address, leave the busy bit set (reserve wins) and still store the data.
REQ-014 SHALL register RdBusy[i] with RdData[i] as the post-edge busy state of RdAddr[i], so a write in the same cycle reports not busy.
REQ-015 SHALL ignore reads of an address while RdEn is low; out-of-range addresses cannot occur because depth is a full power of two.

Reset
REQ-016 SHALL, while RESET=0, asynchronously clear all registers, all busy bits, RdData and RdBusy to 0.
REQ-017 SHALL discard writes and reservations presented in the cycle reset deasserts only if RESET is still low at that edge; the first edge with RESET=1 operates normally.

Structure
REQ-018 SHALL place the default widths and a packed-port slice helper constant (address and data slice widths) in a shared package, regfile_pkg.
REQ-019 SHALL implement the busy scoreboard as sub-module regfile_scoreboard (reserve and clear inputs, per-read busy outputs).
REQ-020 SHALL use only synthesizable constructs, with no delays or blocking writes to storage.

Verification
REQ-021 Reset: assert RESET=0 mid-stream, then read r1..r31 -> RdData=0 and RdBusy=0 on every port.
REQ-022 Basic R/W: write r5=0xDEADBEEF, then read r5 next cycle on both ports -> both RdData=0xDEADBEEF one cycle after RdEn.
REQ-023 Bypass and priority: in one cycle, port0 writes r7=0x11, port1 writes r7=0x22, and port0 reads r7 -> RdData0=0x22, and a later read of r7 returns 0x22.
REQ-024 Zero register: write r0=0xFFFFFFFF and ResvEn on r0, then read r0 -> RdData=0, RdBusy=0.
REQ-025 Scoreboard: reserve r9, read r9 -> RdBusy=1; write r9=0x5 while reading r9 -> RdData=0x5, RdBusy=0; reserve and write r9 together -> next read RdBusy=1.
REQ-026 Hold: read r3=0xA, deassert RdEn, then write r3=0xB -> RdData stays 0xA until RdEn is reasserted.
